// File: rtl/hft_pkg.sv
// Shared types and constants for the order transmit path.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package hft_pkg;

    localparam logic [7:0] SOF_BYTE  = 8'hA5;
    localparam int         FRAME_LEN = 8;

    // One queued order: 48 bits, addr in the top byte.
    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  buysell;
        logic [31:0] timestamp;
    } order_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Byte idx of the fixed 8-byte frame built from one order.
    function automatic logic [7:0] frame_byte(input order_t ord,
                                              input logic [2:0] idx,
                                              input logic [7:0] sof);
        logic [7:0] b;
        case (idx)
            3'd0:    b = sof;
            3'd1:    b = ord.addr;
            3'd2:    b = ord.buysell;
            3'd3:    b = ord.timestamp[31:24];
            3'd4:    b = ord.timestamp[23:16];
            3'd5:    b = ord.timestamp[15:8];
            3'd6:    b = ord.timestamp[7:0];
            default: b = ord.addr ^ ord.buysell ^ ord.timestamp[31:24] ^
                         ord.timestamp[23:16] ^ ord.timestamp[15:8] ^ ord.timestamp[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous order FIFO, DEPTH entries, extra-MSB pointers for full/empty.
// Latency: a written entry is visible on dout (first-word fall-through) the cycle after push.
// Backpressure: push ignored while full, pop ignored while empty; full_nxt previews fullness after the edge.
module order_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         full_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [W-1:0] mem [DEPTH];
    logic         wr_en, rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_en};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_en};

    // Same index with differing wrap bit means every slot is occupied.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign full_nxt = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    assign dout     = mem[rd_ptr[AW-1:0]];

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/order_tx_framer.sv
// Queues orders and serializes each into an 8-byte frame (SOF, addr, buysell, ts x4, xor checksum).
// Latency: order strobed at edge E0 into an idle, empty framer shows byte 0 after edge E1; 8 cycles/frame min.
// Backpressure: bytes hold while byte_ready=0; tx_busy flags a full queue and further orders are dropped and counted.
module order_tx_framer
    import hft_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [7:0] SOF   = SOF_BYTE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  tx_addr,
    input  logic [7:0]  tx_buysell,
    input  logic [31:0] tx_timestamp,
    input  logic        tx_dv,
    output logic        tx_busy,
    output logic [7:0]  byte_out,
    output logic        byte_dv,
    input  logic        byte_ready,
    output logic        frame_active,
    output logic [7:0]  drop_count
);

    order_t    new_ord, head_ord, hold_q;
    tx_state_t state_q, state_d;
    logic [2:0] idx_q;
    logic       pop;
    logic       fifo_full, fifo_empty, fifo_full_nxt;

    assign new_ord = '{addr: tx_addr, buysell: tx_buysell, timestamp: tx_timestamp};

    order_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(order_t))
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (tx_dv),
        .pop      (pop),
        .din      (new_ord),
        .dout     (head_ord),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    // Framing FSM next state and byte-side outputs; outputs are zero outside SEND.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        byte_dv      = 1'b0;
        frame_active = 1'b0;
        byte_out     = 8'h00;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                byte_dv      = 1'b1;
                frame_active = 1'b1;
                byte_out     = frame_byte(hold_q, idx_q, SOF);
                if (byte_ready && (idx_q == 3'(FRAME_LEN - 1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, holding register and byte index; idx wraps to 0 after the last byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                hold_q <= head_ord;
                idx_q  <= '0;
            end else if (state_q == SEND && byte_ready) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // Busy mirrors queue fullness after the edge; drops are judged on fullness before it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy    <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            tx_busy <= fifo_full_nxt;
            if (tx_dv && fifo_full && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_order_tx_framer.sv
module tb_order_tx_framer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  tx_addr = '0;
    logic [7:0]  tx_buysell = '0;
    logic [31:0] tx_timestamp = '0;
    logic        tx_dv = 1'b0;
    logic        tx_busy;
    logic [7:0]  byte_out;
    logic        byte_dv;
    logic        byte_ready = 1'b0;
    logic        frame_active;
    logic [7:0]  drop_count;

    order_tx_framer #(.DEPTH(DEPTH), .SOF(8'hA5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_addr      (tx_addr),
        .tx_buysell   (tx_buysell),
        .tx_timestamp (tx_timestamp),
        .tx_dv        (tx_dv),
        .tx_busy      (tx_busy),
        .byte_out     (byte_out),
        .byte_dv      (byte_dv),
        .byte_ready   (byte_ready),
        .frame_active (frame_active),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: queued records, bytes still owed for the frame in flight, drop tally.
    logic [47:0] mq[$];
    logic [7:0]  cur[$];
    bit          sending;
    int          drops;

    logic [7:0]  got[$];     // bytes actually transferred downstream
    bit          dvhist[$];  // byte_dv per cycle

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cur.delete();
        sending = 0;
        drops   = 0;
    endtask

    task automatic model_frame(input logic [47:0] r);
        logic [7:0] a, b, c;
        logic [31:0] ts;
        a  = r[47:40];
        b  = r[39:32];
        ts = r[31:0];
        c  = a ^ b ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
        cur.delete();
        cur.push_back(8'hA5);
        cur.push_back(a);
        cur.push_back(b);
        cur.push_back(ts[31:24]);
        cur.push_back(ts[23:16]);
        cur.push_back(ts[15:8]);
        cur.push_back(ts[7:0]);
        cur.push_back(c);
    endtask

    // One clock edge of the reference: pop/send uses pre-edge state, push uses pre-edge fullness.
    task automatic model_edge(input bit dv, input logic [47:0] rec, input bit rdy);
        bit full0, ne0;
        full0 = (mq.size() == DEPTH);
        ne0   = (mq.size() > 0);
        if (sending) begin
            if (rdy) begin
                void'(cur.pop_front());
                if (cur.size() == 0) sending = 0;
            end
        end else if (ne0) begin
            model_frame(mq.pop_front());
            sending = 1;
        end
        if (dv) begin
            if (!full0) mq.push_back(rec);
            else if (drops < 255) drops++;
        end
    endtask

    task automatic check_outputs();
        chk("byte_dv", byte_dv, sending);
        chk("frame_active", frame_active, sending);
        chk("byte_out", byte_out, sending ? cur[0] : 8'h00);
        chk("tx_busy", tx_busy, mq.size() == DEPTH);
        chk("drop_count", drop_count, drops);
    endtask

    // Called at posedge+1: check, drive this cycle's inputs, advance one edge.
    task automatic cycle(input bit dv, input logic [7:0] a, input logic [7:0] b,
                         input logic [31:0] ts, input bit rdy);
        check_outputs();
        dvhist.push_back(byte_dv);
        tx_dv        = dv;
        tx_addr      = a;
        tx_buysell   = b;
        tx_timestamp = ts;
        byte_ready   = rdy;
        if (byte_dv && rdy) got.push_back(byte_out);
        model_edge(dv, {a, b, ts}, rdy);
        @(posedge clk);
        #1;
        tx_dv = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 8'h00, 32'h0, rdy);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_byte_dv", byte_dv, 0);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_byte_out", byte_out, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_drop_count", drop_count, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_single_frame(input string tag);
        logic [7:0] ref_bytes [8];
        ref_bytes = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        chk({tag, "_count"}, got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got.size()) chk({tag, "_byte"}, got[i], ref_bytes[i]);
    endtask

    initial begin
        logic [7:0] prev_out;
        bit         prev_hold;
        int         first, ones1, zeros, ones2, k;
        int         dv_pct, rdy_pct;

        // Reset state
        model_reset();
        do_reset();
        idle(3, 1);

        // Single order, latency, exact byte sequence
        got.delete();
        cycle(1, 8'h00, 8'h01, 32'h12345678, 1);
        chk("lat_e0_dv", byte_dv, 0);
        cycle(0, 8'h00, 8'h00, 32'h0, 1);
        chk("lat_e1_dv", byte_dv, 1);
        chk("lat_e1_sof", byte_out, 8'hA5);
        idle(10, 1);
        check_single_frame("single");
        chk("single_done", frame_active, 0);

        // Backpressure with ready pattern 1,0,0,1,...
        got.delete();
        cycle(1, 8'h00, 8'h01, 32'h12345678, 1);
        prev_hold = 0;
        prev_out  = 8'h00;
        for (int i = 0; i < 30; i++) begin
            bit r;
            r = (i % 4 == 0) || (i % 4 == 3);
            if (prev_hold) chk("bp_stable", byte_out, prev_out);
            prev_hold = byte_dv && !r;
            prev_out  = byte_out;
            cycle(0, 8'h00, 8'h00, 32'h0, r);
        end
        check_single_frame("bp");

        // Overflow: 5 pushes fill register + FIFO, then a 6th is dropped
        for (int rep = 5; rep <= 6; rep++) begin
            do_reset();
            got.delete();
            for (int a = 1; a <= rep; a++) cycle(1, 8'(a), 8'h01, $urandom, 0);
            chk("ovf_dv", byte_dv, 1);
            chk("ovf_sof", byte_out, 8'hA5);
            chk("ovf_busy", tx_busy, 1);
            chk("ovf_drops", drop_count, rep - 5);
            idle(60, 1);
            chk("ovf_bytes", got.size(), 40);
            for (int f = 0; f < 5; f++)
                if (8 * f + 1 < got.size()) chk("ovf_order", got[8*f+1], f + 1);
        end

        // Saturation of the drop counter
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1, 8'($urandom), 8'h02, $urandom, 0);
        chk("sat_drops", drop_count, 255);

        // Reset mid-frame after byte 3
        do_reset();
        got.delete();
        cycle(1, 8'h33, 8'h44, $urandom, 1);
        for (int i = 0; i < 20 && got.size() < 3; i++) cycle(0, 8'h00, 8'h00, 32'h0, 1);
        chk("mid_sent", got.size(), 3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dv", byte_dv, 0);
        chk("mid_rst_active", frame_active, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        got.delete();
        idle(12, 1);
        chk("mid_no_resume", got.size(), 0);
        cycle(1, 8'h55, 8'h66, $urandom, 1);
        idle(3, 1);
        chk("mid_new_sof", got.size() > 0 ? got[0] : 8'hxx, 8'hA5);

        // Back-to-back: two frames, one idle cycle between
        idle(10, 1);
        got.delete();
        dvhist.delete();
        cycle(1, 8'h0A, 8'h01, $urandom, 1);
        cycle(1, 8'h0B, 8'h02, $urandom, 1);
        idle(25, 1);
        first = 0;
        while (first < dvhist.size() && !dvhist[first]) first++;
        k = first; ones1 = 0; zeros = 0; ones2 = 0;
        while (k < dvhist.size() && dvhist[k])  begin ones1++; k++; end
        while (k < dvhist.size() && !dvhist[k]) begin zeros++; k++; end
        while (k < dvhist.size() && dvhist[k])  begin ones2++; k++; end
        chk("b2b_frame1", ones1, 8);
        chk("b2b_gap", zeros, 1);
        chk("b2b_frame2", ones2, 8);
        chk("b2b_bytes", got.size(), 16);

        // Randomized traffic against the reference model
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            dv_pct  = $urandom_range(10, 80);
            rdy_pct = $urandom_range(20, 100);
            for (int i = 0; i < 500; i++)
                cycle(($urandom % 100) < dv_pct, 8'($urandom), 8'($urandom), $urandom,
                      ($urandom % 100) < rdy_pct);
        end
        idle(60, 1);
        chk("rand_drained", byte_dv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
